// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: buffers uart RX bytes in a FIFO, decodes single-character
// commands into per-channel run/clear controls for NUM_CH counter channels,
// and echoes each popped byte (or '?' when invalid) back on the uart TX path.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for a byte in the FIFO; pops the head when present
// DECODE    | applies the popped command; launches the echo if enabled
// ECHO_REQ  | o_tx_start high for this single cycle
// ECHO_WAIT | waiting for i_tx_done, abandoned after TX_TIMEOUT cycles
module uart_cmd_ctrl #(
    parameter int FIFO_DEPTH = 8,
    parameter int NUM_CH     = 2,
    parameter int ECHO_EN    = 1,
    parameter int TX_TIMEOUT = 1_000_000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    i_rx_data,
    input  logic                          i_rx_done,
    output logic                          o_tx_start,
    output logic [7:0]                    o_tx_data,
    input  logic                          i_tx_done,
    output logic [NUM_CH-1:0]             o_run,
    output logic [NUM_CH-1:0]             o_clear,
    output logic [1:0]                    o_sel,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
    output logic                          o_overflow,
    output logic                          o_tx_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    // Timer only needs to hold TX_TIMEOUT-1.
    localparam int TW = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        ECHO_REQ,
        ECHO_WAIT
    } state_t;

    state_t              state_q;
    logic [7:0]          mem_q [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [AW:0]         count_q, count_d;
    logic                full, do_push, do_pop;

    logic [7:0]          byte_q;
    logic [NUM_CH-1:0]   run_q, clear_q, sel_mask;
    logic [1:0]          sel_q;
    logic                tx_start_q, overflow_q, tx_err_q;
    logic [7:0]          tx_data_q;
    logic [TW-1:0]       timer_q;
    logic                digit_ok, cmd_valid;

    // A pop frees a slot in the same cycle, so a push into a full FIFO is
    // still accepted when the FSM is popping.
    assign full    = (count_q == (AW+1)'(FIFO_DEPTH));
    assign do_pop  = (state_q == IDLE) && (count_q != '0);
    assign do_push = i_rx_done && (!full || do_pop);

    // Occupancy next-state from the push/pop pair.
    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FIFO storage; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= i_rx_data;
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            if (i_rx_done && full && !do_pop) overflow_q <= 1'b1;
        end
    end

    // Command classification of the popped byte.
    assign sel_mask  = NUM_CH'(1) << sel_q;
    assign digit_ok  = (byte_q[7:2] == 6'b001100) &&
                       ({1'b0, byte_q[1:0]} < 3'(NUM_CH));
    assign cmd_valid = digit_ok || (byte_q == 8'h67) || (byte_q == 8'h73) ||
                       (byte_q == 8'h72) || (byte_q == 8'h63) || (byte_q == 8'h78);

    // Control FSM with registered command and echo outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            byte_q     <= '0;
            run_q      <= '0;
            clear_q    <= '0;
            sel_q      <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            tx_err_q   <= 1'b0;
            timer_q    <= '0;
        end else begin
            clear_q    <= '0;
            tx_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (count_q != '0) begin
                        byte_q  <= mem_q[rd_ptr_q];
                        state_q <= DECODE;
                    end
                end
                DECODE: begin
                    if (digit_ok) sel_q <= byte_q[1:0];
                    case (byte_q)
                        8'h67:   run_q   <= run_q | sel_mask;
                        8'h73:   run_q   <= run_q & ~sel_mask;
                        8'h72:   run_q   <= run_q ^ sel_mask;
                        8'h63:   clear_q <= sel_mask;
                        8'h78: begin
                            run_q   <= '0;
                            clear_q <= '1;
                        end
                        default: ;
                    endcase
                    if (ECHO_EN != 0) begin
                        tx_start_q <= 1'b1;
                        tx_data_q  <= cmd_valid ? byte_q : 8'h3F;
                        state_q    <= ECHO_REQ;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ECHO_REQ: begin
                    timer_q <= TW'(TX_TIMEOUT - 1);
                    state_q <= ECHO_WAIT;
                end
                ECHO_WAIT: begin
                    if (i_tx_done) begin
                        state_q <= IDLE;
                    end else if (timer_q == '0) begin
                        tx_err_q <= 1'b1;
                        state_q  <= IDLE;
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_tx_start   = tx_start_q;
    assign o_tx_data    = tx_data_q;
    assign o_run        = run_q;
    assign o_clear      = clear_q;
    assign o_sel        = sel_q;
    assign o_fifo_count = count_q;
    assign o_overflow   = overflow_q;
    assign o_tx_err     = tx_err_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Testbench for uart_cmd_ctrl: directed scenarios plus randomized command
// bursts, with echoes and channel outputs checked against a command model.
module tb_uart_cmd_ctrl;

    localparam int FIFO_DEPTH = 8;
    localparam int NUM_CH     = 2;
    localparam int TX_TIMEOUT = 50;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] i_rx_data = '0;
    logic       i_rx_done = 1'b0;
    logic       o_tx_start;
    logic [7:0] o_tx_data;
    logic       i_tx_done = 1'b0;
    logic [1:0] o_run, o_clear, o_sel;
    logic [3:0] o_fifo_count;
    logic       o_overflow, o_tx_err;

    uart_cmd_ctrl #(
        .FIFO_DEPTH(FIFO_DEPTH), .NUM_CH(NUM_CH), .ECHO_EN(1), .TX_TIMEOUT(TX_TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .i_rx_data(i_rx_data), .i_rx_done(i_rx_done),
        .o_tx_start(o_tx_start), .o_tx_data(o_tx_data), .i_tx_done(i_tx_done),
        .o_run(o_run), .o_clear(o_clear), .o_sel(o_sel), .o_fifo_count(o_fifo_count),
        .o_overflow(o_overflow), .o_tx_err(o_tx_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Snapshot of the outputs during each o_tx_start cycle.
    typedef struct {
        logic [7:0] data;
        logic [1:0] sel;
        logic [1:0] run;
        logic [1:0] clr;
    } obs_t;
    obs_t obs_q[$];

    always @(negedge clk) begin
        if (o_tx_start) obs_q.push_back('{o_tx_data, o_sel, o_run, o_clear});
    end

    // Command-level reference model.
    logic [7:0] exp_q[$];
    logic [1:0] m_run = '0;
    int         m_sel = 0;

    task automatic model_apply(input logic [7:0] b, output logic [7:0] echo, output logic [1:0] clr);
        logic [1:0] ch;
        ch   = 2'b01 << m_sel;
        clr  = 2'b00;
        echo = b;
        if (b >= "0" && b <= "3") begin
            if (int'(b) - int'("0") < NUM_CH) m_sel = int'(b) - int'("0");
            else echo = "?";
        end else begin
            case (b)
                "g":     m_run = m_run | ch;
                "s":     m_run = m_run & ~ch;
                "r":     m_run = m_run ^ ch;
                "c":     clr = ch;
                "x": begin
                    m_run = 2'b00;
                    clr   = 2'b11;
                end
                default: echo = "?";
            endcase
        end
    endtask

    function automatic logic [7:0] rand_cmd();
        case ($urandom_range(0, 10))
            0: return "0";
            1: return "1";
            2: return "2";
            3: return "3";
            4: return "g";
            5: return "s";
            6: return "r";
            7: return "c";
            8: return "x";
            9: return 8'($urandom_range(0, 255));
            default: return "G";
        endcase
    endfunction

    typedef logic [7:0] bq_t[$];

    // Back-to-back pushes, one per cycle; only the first n_acc enter the model.
    task automatic push_burst(input bq_t bytes, input int n_acc);
        foreach (bytes[i]) begin
            @(negedge clk);
            i_rx_done = 1'b1;
            i_rx_data = bytes[i];
            if (i < n_acc) exp_q.push_back(bytes[i]);
        end
        @(negedge clk);
        i_rx_done = 1'b0;
    endtask

    // Waits for the next echo and checks it against the model.
    task automatic check_echo();
        obs_t       o;
        logic [7:0] b, echo;
        logic [1:0] clr;
        for (int c = 0; c < 200 && obs_q.size() == 0; c++) @(posedge clk);
        if (obs_q.size() == 0) begin
            chk("echo_seen", 32'(obs_q.size()), 32'd1);
            return;
        end
        o = obs_q.pop_front();
        if (exp_q.size() == 0) begin
            chk("echo_expected", 32'(exp_q.size()), 32'd1);
            return;
        end
        b = exp_q.pop_front();
        model_apply(b, echo, clr);
        chk("echo_data", 32'(o.data), 32'(echo));
        chk("echo_sel",  32'(o.sel),  32'(m_sel));
        chk("echo_run",  32'(o.run),  32'(m_run));
        chk("echo_clr",  32'(o.clr),  32'(clr));
    endtask

    task automatic send_done(input int delay);
        repeat (delay) @(negedge clk);
        i_tx_done = 1'b1;
        @(negedge clk);
        i_tx_done = 1'b0;
    endtask

    task automatic service(input int delay);
        check_echo();
        send_done(delay);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_run",   32'(o_run), 32'd0);
        chk("rst_clear", 32'(o_clear), 32'd0);
        chk("rst_sel",   32'(o_sel), 32'd0);
        chk("rst_start", 32'(o_tx_start), 32'd0);
        chk("rst_txdata", 32'(o_tx_data), 32'd0);
        chk("rst_count", 32'(o_fifo_count), 32'd0);
        chk("rst_ovf",   32'(o_overflow), 32'd0);
        chk("rst_txerr", 32'(o_tx_err), 32'd0);
        reset = 1'b1;
        m_run = '0;
        m_sel = 0;
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        int n;
        bq_t bq;

        do_reset();

        // '1' then 'g', each echo answered 10 cycles later.
        push_burst('{"1", "g"}, 2);
        service(10);
        service(10);
        chk("t1_sel", 32'(o_sel), 32'd1);
        chk("t1_run", 32'(o_run), 32'b10);
        chk("t1_txerr", 32'(o_tx_err), 32'd0);

        // Select channel 0, then 'c' with exact latency checks.
        push_burst('{"0"}, 1);
        service(4);
        @(negedge clk);
        i_rx_done = 1'b1;
        i_rx_data = "c";
        exp_q.push_back("c");
        @(negedge clk);
        i_rx_done = 1'b0;
        chk("t2_cnt_k", 32'(o_fifo_count), 32'd1);
        chk("t2_clr_k", 32'(o_clear), 32'd0);
        @(negedge clk);
        chk("t2_cnt_k1", 32'(o_fifo_count), 32'd0);
        chk("t2_clr_k1", 32'(o_clear), 32'd0);
        @(negedge clk);
        chk("t2_clr_k2", 32'(o_clear), 32'b01);
        chk("t2_start_k2", 32'(o_tx_start), 32'd1);
        chk("t2_run_k2", 32'(o_run), 32'b10);
        @(negedge clk);
        chk("t2_clr_k3", 32'(o_clear), 32'd0);
        service(3);

        // Invalid commands: no change, '?' echoes.
        push_burst('{"7", "Q"}, 2);
        service(5);
        service(5);
        chk("t3_sel", 32'(o_sel), 32'd0);
        chk("t3_run", 32'(o_run), 32'b10);

        // Ten bytes with no tx_done: one popped, eight held, tenth dropped.
        push_burst('{"g", "1", "g", "r", "s", "c", "x", "0", "r", "g"}, 9);
        chk("t4_count", 32'(o_fifo_count), 32'd8);
        chk("t4_ovf", 32'(o_overflow), 32'd1);
        check_echo();
        for (int c = 0; c < 3 * TX_TIMEOUT && !o_tx_err; c++) @(negedge clk);
        chk("t4_txerr", 32'(o_tx_err), 32'd1);
        for (int i = 0; i < 8; i++) service($urandom_range(1, 10));
        chk("t4_drained", 32'(o_fifo_count), 32'd0);

        do_reset();

        // Fill to exactly full, then push in the pop cycle and in a no-pop cycle.
        bq.delete();
        for (int i = 0; i < 9; i++) bq.push_back(rand_cmd());
        push_burst(bq, 9);
        chk("t5_full", 32'(o_fifo_count), 32'd8);
        chk("t5_noovf", 32'(o_overflow), 32'd0);
        check_echo();
        @(negedge clk);
        i_tx_done = 1'b1;
        @(negedge clk);
        i_tx_done = 1'b0;
        i_rx_done = 1'b1;
        i_rx_data = "r";
        exp_q.push_back("r");
        @(negedge clk);
        chk("t5_popcnt", 32'(o_fifo_count), 32'd8);
        chk("t5_popovf", 32'(o_overflow), 32'd0);
        i_rx_data = "s";
        @(negedge clk);
        i_rx_done = 1'b0;
        chk("t5_dropcnt", 32'(o_fifo_count), 32'd8);
        chk("t5_dropovf", 32'(o_overflow), 32'd1);
        for (int i = 0; i < 9; i++) service($urandom_range(1, 12));
        chk("t5_drained", 32'(o_fifo_count), 32'd0);

        do_reset();

        // Randomized command bursts against the model.
        for (int it = 0; it < 30; it++) begin
            n = $urandom_range(1, 4);
            bq.delete();
            for (int i = 0; i < n; i++) bq.push_back(rand_cmd());
            push_burst(bq, n);
            for (int i = 0; i < n; i++) service($urandom_range(1, 12));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        chk("rand_count", 32'(o_fifo_count), 32'd0);
        chk("rand_txerr", 32'(o_tx_err), 32'd0);
        chk("rand_ovf", 32'(o_overflow), 32'd0);

        do_reset();

        // Reset during ECHO_WAIT with bytes still queued.
        push_burst('{"g", "r", "1"}, 3);
        check_echo();
        repeat (3) @(negedge clk);
        chk("t6_run_pre", 32'(o_run), 32'b01);
        reset = 1'b0;
        @(negedge clk);
        chk("t6_count", 32'(o_fifo_count), 32'd0);
        chk("t6_run", 32'(o_run), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        obs_q.delete();
        m_run = '0;
        m_sel = 0;
        repeat (100) @(negedge clk);
        chk("t6_no_start", 32'(obs_q.size()), 32'd0);
        chk("t6_count_post", 32'(o_fifo_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errs);
        $fatal(1);
    end

endmodule

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
- Parametrised successor to the single-channel UART-to-counter glue.
- Sits between the byte-level uart core (rx/tx byte handshakes) and NUM_CH up-counter/FND channels.
- Buffers received bytes in a FIFO, decodes single-character ASCII commands into per-channel run/clear controls, and echoes each accepted byte (or '?') back through the uart tx path with a timeout guard.

Parameters:
- FIFO_DEPTH, 8: RX byte FIFO depth; power of 2, range 2..64.
- NUM_CH, 2: number of controlled counter channels; range 1..4.
- ECHO_EN, 1: 1 echoes every popped byte via tx; 0 disables all tx activity.
- TX_TIMEOUT, 1_000_000: cycles to wait for i_tx_done before abandoning an echo.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset.
- i_rx_data  input  8  received byte from uart; valid when i_rx_done=1.
- i_rx_done  input  1  one-cycle strobe, byte received.
- o_tx_start  output  1  one-cycle strobe to uart tx.
- o_tx_data  output  8  byte to transmit; held stable from o_tx_start until echo completes.
- i_tx_done  input  1  one-cycle strobe, uart tx finished.
- o_run  output  NUM_CH  per-channel run enable (level).
- o_clear  output  NUM_CH  per-channel clear (one-cycle pulse).
- o_sel  output  2  currently selected channel index.
- o_fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes held in RX FIFO.
- o_overflow  output  1  sticky, byte dropped on full FIFO.
- o_tx_err  output  1  sticky, echo timed out.

Behaviour:
- Reset (reset=0 at a clk edge): FIFO emptied, FSM=IDLE, all outputs 0 (o_run=0, o_clear=0, o_sel=0, o_tx_start=0, o_tx_data=0, o_fifo_count=0, both stickies 0). Reset mid-echo abandons the echo; no further o_tx_start.
- FIFO push: on an edge with i_rx_done=1 and not full, the byte is written and count increments.
  - Full with no pop that cycle: byte dropped, o_overflow set (cleared only by reset).
  - Push and pop in the same cycle: both happen, count unchanged, including when full.
- FSM states: IDLE, DECODE, ECHO_REQ, ECHO_WAIT.
  - IDLE: if count>0, pop the head into a byte register, then go to DECODE.
  - DECODE (1 cycle): apply the command, then go to ECHO_REQ if ECHO_EN=1, else IDLE.
  - ECHO_REQ (1 cycle): o_tx_start=1, o_tx_data = byte (valid) or 8'h3F '?' (invalid), then go to ECHO_WAIT.
  - ECHO_WAIT: on i_tx_done go to IDLE. If TX_TIMEOUT cycles elapse without i_tx_done, set o_tx_err and go to IDLE. i_tx_done in any other state is ignored.
- Command set (lowercase ASCII only; everything else is invalid, no state change):
  - '0'..'3': o_sel <= digit. Invalid if digit >= NUM_CH.
  - 'g': o_run[o_sel] <= 1.
  - 's': o_run[o_sel] <= 0.
  - 'r': o_run[o_sel] toggles.
  - 'c': o_clear[o_sel] pulses 1 cycle; o_run unchanged.
  - 'x': o_run <= 0 and o_clear pulses on all channels in the same cycle.
- Latency, with the FSM in IDLE and the FIFO empty:
  - i_rx_done sampled at edge k; byte is in the FIFO after k.
  - Popped at k+1; command outputs updated at k+2.
  - o_tx_start is high during the cycle after edge k+2.
- Throughput: one command per echo round-trip. With ECHO_EN=0, one command per 2 cycles.
- o_fifo_count reflects count after each edge; it never exceeds FIFO_DEPTH. Read/write pointers wrap modulo FIFO_DEPTH.

Test Plan:
- Reset, then push '1','g' (NUM_CH=2), answering each o_tx_start with i_tx_done 10 cycles later -> o_sel=1, o_run=2'b10; tx echoes 8'h31 then 8'h67; o_tx_err=0.
- Push 'c' with o_sel=0 -> o_clear=2'b01 for exactly 1 cycle, 2 cycles after i_rx_done; o_run unchanged.
- Push '7' and 'Q' -> no output change; two echoes of 8'h3F.
- Hold i_tx_done low, push 10 bytes back-to-back with FIFO_DEPTH=8 -> o_fifo_count saturates at 8; o_overflow=1; after TX_TIMEOUT (set to 50 in bench), o_tx_err=1 and draining continues.
- Push during a full-FIFO pop cycle -> byte accepted, count stays 8, o_overflow not newly set.
- Assert reset=0 in ECHO_WAIT with bytes queued -> next cycle count=0, o_run=0, no o_tx_start after release.
